// File: rtl/wb_slot_scheduler.sv
// -----------------------------------------------------------------------------
// wb_slot_scheduler
//
// Issue-side scheduler for the single architectural-register-file write port
// shared by three fixed-latency units: ALU/misc (idx 0), multiplier (idx 1)
// and load/store (idx 2). At most one issue is granted per cycle, round-robin
// among the requesters whose writeback cycle is still free. A shift-register
// reservation table drives the writeback mux select and a sticky flag that
// records any disagreement between actual unit writeback activity and the
// table.
//
// Handshake: req_i[i] is a level request that the unit holds until it sees
// grant_o[i]=1 in the same cycle; the unit samples its issue inputs at the
// rising edge that ends a granted cycle. A request that is not granted leaves
// no state behind and is simply retried next cycle.
//
// Ports
//   clk_i         single clock, rising edge
//   rst_ni        asynchronous active-low reset
//   req_i[2:0]    per-unit issue request ([0] ALU, [1] MUL, [2] MEM)
//   stall_i       issue stall: no grant and no reservation this cycle
//   fu_wb_oper_i  per-unit "result valid on WB outputs this cycle"
//   grant_o       one-hot (or zero) combinational issue grant
//   wb_valid_o    registered: a reserved writeback happens this cycle
//   wb_sel_o      registered: WB mux select (0 ALU, 1 MUL, 2 MEM), 0 if idle
//   wb_err_o      registered sticky: WB activity disagreed with the table
// -----------------------------------------------------------------------------
module wb_slot_scheduler #(
  parameter int unsigned LAT_ALU = 4,
  parameter int unsigned LAT_MUL = 6,
  parameter int unsigned LAT_MEM = 5
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [2:0] req_i,
  input  logic       stall_i,
  input  logic [2:0] fu_wb_oper_i,
  output logic [2:0] grant_o,
  output logic       wb_valid_o,
  output logic [1:0] wb_sel_o,
  output logic       wb_err_o
);

  localparam int unsigned MAX_AM  = (LAT_ALU > LAT_MUL) ? LAT_ALU : LAT_MUL;
  localparam int unsigned MAX_LAT = (MAX_AM > LAT_MEM) ? MAX_AM : LAT_MEM;

  // slot_q[k] set means the WB port is already used k cycles from now.
  logic [MAX_LAT:0]       slot_q, slot_d;
  logic [MAX_LAT:0][1:0]  owner_q, owner_d;
  logic [1:0]             rr_q, rr_d;
  logic                   err_q, err_d;

  logic [2:0] elig;
  logic [1:0] cand;
  logic [1:0] gidx;
  logic       gvalid;
  logic [2:0] exp_oper;

  // A unit with latency L granted now writes back L cycles from now, which is
  // what slot_q[L] describes in this cycle. Reset gates the grant so it is
  // zero for as long as rst_ni is low.
  assign elig[0] = req_i[0] & ~stall_i & ~slot_q[LAT_ALU] & rst_ni;
  assign elig[1] = req_i[1] & ~stall_i & ~slot_q[LAT_MUL] & rst_ni;
  assign elig[2] = req_i[2] & ~stall_i & ~slot_q[LAT_MEM] & rst_ni;

  // Round-robin scan starting at rr_q, wrapping 2 -> 0.
  always_comb begin
    grant_o = 3'b000;
    gidx    = 2'd0;
    gvalid  = 1'b0;
    cand    = rr_q;
    for (int k = 0; k < 3; k++) begin
      if (!gvalid && elig[cand]) begin
        gvalid = 1'b1;
        gidx   = cand;
      end
      cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
    end
    if (gvalid) grant_o = 3'b001 << gidx;
  end

  always_comb begin
    slot_d  = {1'b0, slot_q[MAX_LAT:1]};
    owner_d = {2'b00, owner_q[MAX_LAT:1]};
    // The reservation lands at LAT-1 because the table shifts on this same
    // edge; for a latency of 1 that is slot 0 directly.
    if (grant_o[0]) begin
      slot_d[LAT_ALU-1]  = 1'b1;
      owner_d[LAT_ALU-1] = 2'd0;
    end
    if (grant_o[1]) begin
      slot_d[LAT_MUL-1]  = 1'b1;
      owner_d[LAT_MUL-1] = 2'd1;
    end
    if (grant_o[2]) begin
      slot_d[LAT_MEM-1]  = 1'b1;
      owner_d[LAT_MEM-1] = 2'd2;
    end

    rr_d = rr_q;
    if (gvalid) rr_d = (gidx == 2'd2) ? 2'd0 : gidx + 2'd1;

    exp_oper = slot_q[0] ? (3'b001 << owner_q[0]) : 3'b000;
    err_d    = err_q | (fu_wb_oper_i != exp_oper);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_q  <= '0;
      owner_q <= '0;
      rr_q    <= 2'd0;
      err_q   <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
    end
  end

  // Outputs come straight from flops: no combinational path from req_i.
  assign wb_valid_o = slot_q[0];
  assign wb_sel_o   = slot_q[0] ? owner_q[0] : 2'd0;
  assign wb_err_o   = err_q;

endmodule

// File: tb/tb_wb_slot_scheduler.sv
// -----------------------------------------------------------------------------
// tb_wb_slot_scheduler
//
// Bench for wb_slot_scheduler. The reference model keeps writeback
// reservations as a map from absolute cycle number to owning unit, so a grant
// in cycle t for unit i simply books cycle t+LAT_i. Inputs are driven 1 time
// unit after the rising edge; outputs are compared on the falling edge.
// -----------------------------------------------------------------------------
module tb_wb_slot_scheduler;

  localparam int LAT_ALU = 4;
  localparam int LAT_MUL = 6;
  localparam int LAT_MEM = 5;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] req = 3'b000;
  logic       stall = 1'b0;
  logic [2:0] fu_wb_oper = 3'b000;
  logic [2:0] grant;
  logic       wb_valid;
  logic [1:0] wb_sel;
  logic       wb_err;

  always #5 clk = ~clk;

  wb_slot_scheduler #(
    .LAT_ALU(LAT_ALU),
    .LAT_MUL(LAT_MUL),
    .LAT_MEM(LAT_MEM)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_i        (req),
    .stall_i      (stall),
    .fu_wb_oper_i (fu_wb_oper),
    .grant_o      (grant),
    .wb_valid_o   (wb_valid),
    .wb_sel_o     (wb_sel),
    .wb_err_o     (wb_err)
  );

  // ---------------- scoreboard / model state ----------------
  int n_checks = 0;
  int n_errors = 0;
  int t = 0;            // absolute cycle number
  int busy[int];        // reserved WB cycle -> owning unit
  int rr_m = 0;
  bit err_m = 1'b0;
  int lat_m[3] = '{LAT_ALU, LAT_MUL, LAT_MEM};
  logic [2:0] exp_q[$]; // expected grants, popped on check

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask

  // Which unit the schedule allows to issue this cycle (-1 if none).
  function automatic int model_pick(input logic [2:0] r, input logic st);
    int u;
    model_pick = -1;
    if (st) return -1;
    for (int k = 0; k < 3; k++) begin
      u = (rr_m + k) % 3;
      if (r[u] && !busy.exists(t + lat_m[u])) return u;
    end
  endfunction

  // ---------------- driver tasks ----------------
  // One cycle: drive inputs, compare on falling edge, advance the model.
  // When inj is set, fu_wb_oper carries 'bad' instead of the correct pattern.
  task automatic cyc(input logic [2:0] r, input logic st, input bit inj, input logic [2:0] bad);
    int g;
    logic [2:0] good_fu;
    logic [2:0] g_vec;
    good_fu = busy.exists(t) ? (3'b001 << busy[t]) : 3'b000;
    req        = r;
    stall      = st;
    fu_wb_oper = inj ? bad : good_fu;
    g = model_pick(r, st);
    g_vec = (g < 0) ? 3'b000 : (3'b001 << g);
    exp_q.push_back(g_vec);
    @(negedge clk);
    check("grant", 32'(grant), 32'(exp_q.pop_front()));
    check("wb_valid", 32'(wb_valid), 32'(busy.exists(t)));
    check("wb_sel", 32'(wb_sel), busy.exists(t) ? 32'(busy[t]) : 32'd0);
    check("wb_err", 32'(wb_err), 32'(err_m));
    if (fu_wb_oper != good_fu) err_m = 1'b1;
    if (busy.exists(t)) busy.delete(t);
    if (g >= 0) begin
      busy[t + lat_m[g]] = g;
      rr_m = (g + 1) % 3;
    end
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(3'b000, 1'b0, 1'b0, 3'b000);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must drop at once even
  // with every unit requesting.
  task automatic do_reset();
    rst_n      = 1'b0;
    req        = 3'b111;
    stall      = 1'b0;
    fu_wb_oper = 3'b000;
    #1;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_sel", 32'(wb_sel), 32'd0);
    check("rst_wb_err", 32'(wb_err), 32'd0);
    busy.delete();
    rr_m  = 0;
    err_m = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    t++;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    @(posedge clk);
    #1;
    do_reset();

    // Single ALU issue: writeback 4 cycles later.
    cyc(3'b001, 1'b0, 1'b0, 3'b000);
    idle(6);

    // Collision: MUL first, ALU blocked while its WB cycle is taken.
    cyc(3'b010, 1'b0, 1'b0, 3'b000);
    idle(1);
    cyc(3'b001, 1'b0, 1'b0, 3'b000);
    cyc(3'b001, 1'b0, 1'b0, 3'b000);
    idle(6);

    // Round-robin from reset.
    do_reset();
    for (int i = 0; i < 3; i++) cyc(3'b011, 1'b0, 1'b0, 3'b000);
    idle(7);

    // Stall with every unit requesting, then release.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(3'b111, 1'b1, 1'b0, 3'b000);
    cyc(3'b111, 1'b0, 1'b0, 3'b000);
    idle(8);

    // Spurious WB activity with an empty table, sticky until reset.
    do_reset();
    idle(3);
    cyc(3'b000, 1'b0, 1'b1, 3'b010);
    idle(4);
    // Reserved slot with no unit activity.
    do_reset();
    cyc(3'b001, 1'b0, 1'b0, 3'b000);
    idle(3);
    cyc(3'b000, 1'b0, 1'b1, 3'b000);
    idle(3);

    // Reset in the middle of an ALU operation.
    do_reset();
    cyc(3'b001, 1'b0, 1'b0, 3'b000);
    idle(1);
    do_reset();
    idle(3);
    cyc(3'b110, 1'b0, 1'b0, 3'b000);
    idle(7);

    // Random traffic with well-behaved units.
    for (int i = 0; i < 400; i++)
      cyc(3'($urandom_range(0, 7)), ($urandom_range(0, 4) == 0), 1'b0, 3'b000);

    // Random traffic with occasional bad WB activity and resets.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 49) == 0) do_reset();
      else cyc(3'($urandom_range(0, 7)), ($urandom_range(0, 4) == 0),
               ($urandom_range(0, 29) == 0), 3'($urandom_range(0, 7)));
    end

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
